// File: rtl/axi_wr_slave_spram_if.sv
// AXI4 write-channel bundle (AW, W, B) for the single-port RAM write slave.
interface axi_wr_slave_spram_if #(
  parameter int idw = 3
);
  logic [idw:0]  AWID;
  logic [31:0]   AWADDR;
  logic [7:0]    AWLEN;
  logic [2:0]    AWSIZE;
  logic [1:0]    AWBURST;
  logic          AWVALID;
  logic          AWREADY;

  logic [63:0]   WDATA;
  logic [7:0]    WSTRB;
  logic          WLAST;
  logic          WVALID;
  logic          WREADY;

  logic [idw:0]  BID;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY
  );
endinterface

// File: rtl/axi_wr_slave_spram.sv
// AXI4 write slave feeding a 64-bit single-port RAM, one outstanding burst at a time.
// Define AXI_WR_ADDR_CHK_EN to reject bursts that fall outside or wrap the memory.
module axi_wr_slave_spram #(
  parameter int idw    = 3,
  parameter int MEM_AW = 14
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  axi_wr_slave_spram_if.slave  axi,
  output logic                 mem_we,
  output logic [MEM_AW-1:0]    mem_addr,
  output logic [63:0]          mem_wdata,
  output logic [7:0]           mem_be,
  output logic                 o_busy
);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t            state;
  logic [MEM_AW-1:0] waddr;
  logic [7:0]        beat_cnt;
  logic              cfg_err;
  logic              aw_hs;
  logic              w_hs;
  logic              last_beat;
  logic              aw_err;
  logic              unused_bits;

  assign aw_hs     = axi.AWVALID && axi.AWREADY;
  assign w_hs      = axi.WVALID && axi.WREADY;
  assign last_beat = (beat_cnt == 8'd0) || axi.WLAST;
  assign o_busy    = (state != IDLE);

`ifdef AXI_WR_ADDR_CHK_EN
  // A carry out of the word-address field means the burst would wrap past the top of memory.
  logic [MEM_AW+8:0] burst_end;
  assign burst_end   = {9'd0, axi.AWADDR[MEM_AW+2:3]} + {{(MEM_AW+1){1'b0}}, axi.AWLEN};
  assign aw_err      = (axi.AWSIZE != 3'b011) || (axi.AWBURST != 2'b01) ||
                       (axi.AWADDR[31:MEM_AW+3] != '0) ||
                       (burst_end[MEM_AW+8:MEM_AW] != '0);
  assign unused_bits = ^axi.AWADDR[2:0];
`else
  assign aw_err      = (axi.AWSIZE != 3'b011) || (axi.AWBURST != 2'b01);
  assign unused_bits = ^{axi.AWADDR[31:MEM_AW+3], axi.AWADDR[2:0]};
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state       <= IDLE;
      axi.AWREADY <= 1'b0;
      axi.WREADY  <= 1'b0;
      axi.BVALID  <= 1'b0;
      axi.BRESP   <= 2'b00;
      axi.BID     <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      waddr       <= '0;
      beat_cnt    <= '0;
      cfg_err     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        // AWREADY comes up one cycle after entering IDLE, giving AWLEN+4 burst spacing.
        IDLE: begin
          axi.AWREADY <= 1'b1;
          if (aw_hs) begin
            axi.AWREADY <= 1'b0;
            axi.WREADY  <= 1'b1;
            axi.BID     <= axi.AWID;
            waddr       <= axi.AWADDR[MEM_AW+2:3];
            beat_cnt    <= axi.AWLEN;
            cfg_err     <= aw_err;
            state       <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            mem_we    <= !cfg_err;
            mem_addr  <= waddr;
            mem_wdata <= axi.WDATA;
            mem_be    <= axi.WSTRB;
            waddr     <= waddr + MEM_AW'(1);
            beat_cnt  <= beat_cnt - 8'd1;
            // WLAST disagreeing with the beat count flags an early or missing last.
            if (last_beat) begin
              axi.WREADY <= 1'b0;
              axi.BVALID <= 1'b1;
              axi.BRESP  <= (cfg_err || (axi.WLAST ^ (beat_cnt == 8'd0))) ? 2'b10 : 2'b00;
              state      <= RESP;
            end
          end
        end
        RESP: begin
          if (axi.BVALID && axi.BREADY) begin
            axi.BVALID <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_slave_spram.sv
// Directed, table-driven bench for axi_wr_slave_spram (expectations follow AXI_WR_ADDR_CHK_EN).
module tb_axi_wr_slave_spram;

  logic        clk = 1'b0;
  logic        ARESET;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_be;
  logic        o_busy;
  int          total = 0;
  int          bad = 0;

  axi_wr_slave_spram_if #(.idw(3)) axi ();

  axi_wr_slave_spram #(.idw(3), .MEM_AW(14)) dut (
    .ACLK      (clk),
    .ARESET    (ARESET),
    .axi       (axi),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .o_busy    (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          beats;
    int          lastIdx;
    logic [1:0]  expResp;
    bit          expWe;
    logic [13:0] expStart;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " awready"}, axi.AWREADY, 0);
    checkOutput({tag, " wready"}, axi.WREADY, 0);
    checkOutput({tag, " bvalid"}, axi.BVALID, 0);
    checkOutput({tag, " bresp"}, axi.BRESP, 0);
    checkOutput({tag, " bid"}, axi.BID, 0);
    checkOutput({tag, " mem_we"}, mem_we, 0);
    checkOutput({tag, " mem_addr"}, mem_addr, 0);
    checkOutput({tag, " mem_wdata"}, mem_wdata, 0);
    checkOutput({tag, " mem_be"}, mem_be, 0);
    checkOutput({tag, " busy"}, o_busy, 0);
  endtask

  task automatic sendAw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    while (axi.AWREADY !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checkOutput("awready before aw", axi.AWREADY, 1);
    axi.AWID    = id;
    axi.AWADDR  = addr;
    axi.AWLEN   = len;
    axi.AWSIZE  = size;
    axi.AWBURST = burst;
    axi.AWVALID = 1'b1;
    tick();
    axi.AWVALID = 1'b0;
    checkOutput("aw accepted: awready", axi.AWREADY, 0);
    checkOutput("aw accepted: wready", axi.WREADY, 1);
    checkOutput("aw accepted: busy", o_busy, 1);
  endtask

  // One table vector: AW, its beats, per-beat memory checks, then the B response.
  task automatic applyStimulus(input int k, input int holdB);
    logic [63:0] data;
    logic [7:0]  strb;
    logic [13:0] expAddr;
    sendAw(vecs[k].id, vecs[k].addr, vecs[k].len, vecs[k].size, vecs[k].burst);
    for (int i = 0; i < vecs[k].beats; i++) begin
      data = {16'hC0DE, 16'(k), 16'hBEEF, 16'(i)};
      strb = 8'(8'h81 + 8'(i * 3));
      axi.WDATA  = data;
      axi.WSTRB  = strb;
      axi.WLAST  = (i == vecs[k].lastIdx);
      axi.WVALID = 1'b1;
      tick();
      checkOutput($sformatf("v%0d beat%0d mem_we", k, i), mem_we, vecs[k].expWe);
      if (vecs[k].expWe) begin
        expAddr = vecs[k].expStart + 14'(i);
        checkOutput($sformatf("v%0d beat%0d mem_addr", k, i), mem_addr, expAddr);
        checkOutput($sformatf("v%0d beat%0d mem_wdata", k, i), mem_wdata, data);
        checkOutput($sformatf("v%0d beat%0d mem_be", k, i), mem_be, strb);
      end
    end
    axi.WVALID = 1'b0;
    axi.WLAST  = 1'b0;
    checkOutput($sformatf("v%0d wready after end", k), axi.WREADY, 0);
    for (int c = 0; c <= holdB; c++) begin
      checkOutput($sformatf("v%0d bvalid c%0d", k, c), axi.BVALID, 1);
      checkOutput($sformatf("v%0d bid c%0d", k, c), axi.BID, vecs[k].id);
      checkOutput($sformatf("v%0d bresp c%0d", k, c), axi.BRESP, vecs[k].expResp);
      checkOutput($sformatf("v%0d awready in resp c%0d", k, c), axi.AWREADY, 0);
      if (c < holdB) tick();
    end
    axi.BREADY = 1'b1;
    tick();
    axi.BREADY = 1'b0;
    checkOutput($sformatf("v%0d bvalid after hs", k), axi.BVALID, 0);
    checkOutput($sformatf("v%0d awready right after hs", k), axi.AWREADY, 0);
    tick();
    checkOutput($sformatf("v%0d awready one cycle later", k), axi.AWREADY, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{4'h5, 32'h0000_0100, 8'd3, 3'd3, 2'd1, 4, 3, 2'b00, 1'b1, 14'h0020};
    vecs[1] = '{4'h2, 32'h0000_0200, 8'd3, 3'd3, 2'd1, 2, 1, 2'b10, 1'b1, 14'h0040};
    vecs[2] = '{4'h7, 32'h0000_0300, 8'd0, 3'd2, 2'd1, 1, 0, 2'b10, 1'b0, 14'h0060};
    vecs[3] = '{4'h1, 32'h0000_0408, 8'd2, 3'd3, 2'd1, 3, -1, 2'b10, 1'b1, 14'h0081};
    vecs[4] = '{4'h9, 32'h0000_0500, 8'd1, 3'd3, 2'd2, 2, 1, 2'b10, 1'b0, 14'h00A0};
`ifdef AXI_WR_ADDR_CHK_EN
    vecs[5] = '{4'h3, 32'h0001_FFF8, 8'd1, 3'd3, 2'd1, 2, 1, 2'b10, 1'b0, 14'h3FFF};
    vecs[6] = '{4'hA, 32'h8000_0010, 8'd0, 3'd3, 2'd1, 1, 0, 2'b10, 1'b0, 14'h0002};
`else
    vecs[5] = '{4'h3, 32'h0001_FFF8, 8'd1, 3'd3, 2'd1, 2, 1, 2'b00, 1'b1, 14'h3FFF};
    vecs[6] = '{4'hA, 32'h8000_0010, 8'd0, 3'd3, 2'd1, 1, 0, 2'b00, 1'b1, 14'h0002};
`endif
    vecs[7] = '{4'h4, 32'h0000_0018, 8'd0, 3'd3, 2'd1, 1, 0, 2'b00, 1'b1, 14'h0003};

    ARESET      = 1'b1;
    axi.AWID    = '0;
    axi.AWADDR  = '0;
    axi.AWLEN   = '0;
    axi.AWSIZE  = '0;
    axi.AWBURST = '0;
    axi.AWVALID = 1'b0;
    axi.WDATA   = '0;
    axi.WSTRB   = '0;
    axi.WLAST   = 1'b0;
    axi.WVALID  = 1'b0;
    axi.BREADY  = 1'b0;
    tick();
    tick();
    checkResetValues("reset");
    ARESET = 1'b0;
    tick();
    checkOutput("awready after reset release", axi.AWREADY, 1);

    // Stray W beats while idle must be ignored.
    axi.WVALID = 1'b1;
    axi.WLAST  = 1'b1;
    tick();
    tick();
    checkOutput("idle w: wready", axi.WREADY, 0);
    checkOutput("idle w: mem_we", mem_we, 0);
    checkOutput("idle w: busy", o_busy, 0);
    axi.WVALID = 1'b0;
    axi.WLAST  = 1'b0;

    for (int k = 0; k < 8; k++) applyStimulus(k, 0);

    // Slow B consumer: response held stable across five stalled cycles.
    applyStimulus(0, 5);

    // Reset arriving on the second beat of an 8-beat burst.
    sendAw(4'hB, 32'h0000_0800, 8'd7, 3'd3, 2'd1);
    axi.WDATA  = 64'h1234_5678_9ABC_DEF0;
    axi.WSTRB  = 8'hFF;
    axi.WVALID = 1'b1;
    tick();
    checkOutput("midreset beat1 mem_we", mem_we, 1);
    checkOutput("midreset beat1 mem_addr", mem_addr, 14'h0100);
    ARESET = 1'b1;
    tick();
    checkResetValues("midreset");
    ARESET     = 1'b0;
    axi.WVALID = 1'b0;
    axi.BREADY = 1'b1;
    tick();
    checkOutput("post-reset awready", axi.AWREADY, 1);
    checkOutput("post-reset bvalid", axi.BVALID, 0);
    checkOutput("post-reset mem_we", mem_we, 0);
    axi.BREADY = 1'b0;

    applyStimulus(7, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_wr_slave_spram.md
AXI_WR_SLAVE_SPRAM -- requirements
Module: axi_wr_slave_spram

Interface
REQ-001 SHALL have parameter idw, default 3, meaning AXI ID width minus 1.
REQ-002 SHALL have parameter MEM_AW, default 14, meaning memory word-address width (64-bit words).
REQ-003 SHALL have port ACLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port ARESET, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have AW channel inputs AWID [idw:0], AWADDR [31:0], AWLEN [7:0], AWSIZE [2:0], AWBURST [1:0] and AWVALID [1], and AW output AWREADY [1].
REQ-006 SHALL have W channel inputs WDATA [63:0], WSTRB [7:0], WLAST [1] and WVALID [1], and W output WREADY [1].
REQ-007 SHALL have B channel outputs BID [idw:0], BRESP [1:0] and BVALID [1], and B input BREADY [1].
REQ-008 SHALL have memory outputs mem_we [1], mem_addr [MEM_AW-1:0], mem_wdata [63:0] and mem_be [7:0], all registered.
REQ-009 SHALL have output o_busy [1], high whenever the FSM is not IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, DATA and RESP.
REQ-011 IDLE SHALL drive AWREADY=1; on AWVALID&AWREADY it SHALL latch AWID, word address AWADDR[MEM_AW+2:3], AWLEN and an error flag, then go to DATA next cycle.
REQ-012 Error flag SHALL be set at AW acceptance when AWSIZE!=3'b011 or AWBURST!=2'b01 (only 64-bit INCR bursts are supported).
REQ-013 DATA SHALL drive WREADY=1 and AWREADY=0; each WVALID&WREADY beat is accepted with zero wait states.
REQ-014 For each accepted beat, the cycle after the beat SHALL present mem_we=1 (unless error flag set), mem_addr=current word address, mem_wdata=WDATA and mem_be=WSTRB; otherwise mem_we=0.
REQ-015 Word address SHALL increment by 1 per accepted beat, modulo 2^MEM_AW.
REQ-016 Beat counter SHALL load AWLEN at AW acceptance and decrement per beat; the burst ends on the beat where counter==0 or WLAST=1, whichever comes first.
REQ-017 WLAST=1 with counter!=0 (early last) SHALL end the burst and set BRESP=2'b10 (SLVERR).
REQ-018 WLAST=0 with counter==0 (missing last) SHALL end the burst, write that beat, and set BRESP=2'b10.
REQ-019 FSM SHALL go DATA->RESP on the ending beat; the cycle after, BVALID=1, BID=latched AWID, BRESP=2'b00 (OKAY) or 2'b10 (SLVERR) if any error occurred.
REQ-020 BVALID, BID and BRESP SHALL stay stable until BVALID&BREADY; on that handshake BVALID drops and the FSM returns to IDLE in the same cycle.
REQ-021 AWREADY SHALL be 1 again one cycle after the B handshake (single outstanding transaction; back-to-back throughput = AWLEN+4 cycles).
REQ-022 WVALID beats arriving in IDLE or RESP SHALL see WREADY=0 and SHALL NOT be written.
REQ-023 A 1-beat burst (AWLEN=0) SHALL complete as: AW accept in cycle n, W beat in n+1, mem_we in n+2, BVALID in n+2.

Reset
REQ-024 While ARESET=1 at a clock edge, the FSM SHALL go to IDLE and outputs SHALL be AWREADY=0, WREADY=0, BVALID=0, BRESP=0, BID=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, o_busy=0.
REQ-025 AWREADY SHALL rise the first cycle after ARESET deasserts.
REQ-026 ARESET asserted mid-burst SHALL abort the transaction without a B response, and SHALL produce no mem_we in the cycle after the reset edge.

Configuration
REQ-027 Macro AXI_WR_ADDR_CHK_EN SHALL control address range checking.
REQ-028 With AXI_WR_ADDR_CHK_EN defined, the error flag SHALL additionally be set when AWADDR[31:MEM_AW+3]!=0 or when word address+AWLEN>=2^MEM_AW (burst would wrap); for such a burst all beats are accepted, no mem_we is issued, and BRESP=2'b10.
REQ-029 Without AXI_WR_ADDR_CHK_EN, upper address bits SHALL be ignored and the address SHALL wrap per REQ-015.

Verification
REQ-030 Reset, then AWADDR=0x100, AWLEN=3, AWSIZE=3, AWBURST=1, 4 beats with WLAST on the 4th -> mem_we at word addresses 0x20..0x23 with matching data and strobes; BRESP=0; BID equals AWID.
REQ-031 AWLEN=3 with WLAST on beat 2 -> 2 writes, burst ends, BRESP=2'b10, next AW accepted after the B handshake.
REQ-032 AWSIZE=3'b010 with AWLEN=0 -> beat accepted, mem_we stays 0, BRESP=2'b10.
REQ-033 BREADY held low for 5 cycles -> BVALID/BID/BRESP stable for 5 cycles, AWREADY=0 throughout, AWREADY=1 the cycle after BREADY is high.
REQ-034 With AXI_WR_ADDR_CHK_EN, AWADDR=0x0001_FFF8 (MEM_AW=14) with AWLEN=1 -> no mem_we, BRESP=2'b10; without the macro -> writes to word addresses 0x3FFF then 0x0000, BRESP=0.
REQ-035 ARESET pulsed during beat 2 of an AWLEN=7 burst -> all outputs at reset values, no BVALID, AWREADY=1 the cycle after reset releases.
